// File: rtl/sequential_divider.sv
// Multi-cycle restoring divider, signed or unsigned, one quotient bit per clock.
// Results and flags are registered and hold until the next division completes.
module sequential_divider #(
  parameter int BUS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sign,
  input  logic [BUS_WIDTH-1:0] in1,
  input  logic [BUS_WIDTH-1:0] in2,
  output logic                 busy,
  output logic                 done,
  output logic [BUS_WIDTH-1:0] quotient,
  output logic [BUS_WIDTH-1:0] remainder,
  output logic                 z,
  output logic                 n,
  output logic                 dz,
  output logic                 v
);

  localparam int W  = BUS_WIDTH;
  localparam int CW = $clog2(W + 1);
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0] cnt_q;
  logic          sgn_q;
  logic          a_neg_q;
  logic          b_neg_q;
  logic [W-1:0]  raw1_q;
  logic [W-1:0]  raw2_q;
  logic [W-1:0]  dvs_q;
  logic [W-1:0]  quo_q;
  logic [W:0]    rem_q;

  logic          a_neg, b_neg;
  logic [W-1:0]  a_mag, b_mag;
  logic [W:0]    rem_sh, diff;
  logic [W-1:0]  q_sgn, r_sgn;
  logic [W-1:0]  q_fix, r_fix;
  logic          dz_fix, ovf_fix;

  always_comb begin
    a_neg = sign & in1[W-1];
    b_neg = sign & in2[W-1];
    a_mag = a_neg ? ({W{1'b0}} - in1) : in1;
    b_mag = b_neg ? ({W{1'b0}} - in2) : in2;
  end

  // One restoring step: shift next dividend bit in, try the subtract.
  always_comb begin
    rem_sh = {rem_q[W-1:0], quo_q[W-1]};
    diff   = rem_sh - {1'b0, dvs_q};
  end

  always_comb begin
    q_sgn   = (a_neg_q ^ b_neg_q) ? ({W{1'b0}} - quo_q) : quo_q;
    r_sgn   = a_neg_q ? ({W{1'b0}} - rem_q[W-1:0]) : rem_q[W-1:0];
    dz_fix  = (raw2_q == '0);
    ovf_fix = sgn_q & (raw1_q == MIN_NEG) & (raw2_q == '1);
    q_fix   = dz_fix ? '1 : q_sgn;
    r_fix   = dz_fix ? raw1_q : r_sgn;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = CALC;
      CALC: if (cnt_q == '0) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      raw1_q  <= '0;
      raw2_q  <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            cnt_q   <= CW'(W);
            sgn_q   <= sign;
            a_neg_q <= a_neg;
            b_neg_q <= b_neg;
            raw1_q  <= in1;
            raw2_q  <= in2;
            dvs_q   <= b_mag;
            quo_q   <= a_mag;
            rem_q   <= '0;
          end
        end
        CALC: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
            if (diff[W]) begin
              rem_q <= rem_sh;
              quo_q <= {quo_q[W-2:0], 1'b0};
            end else begin
              rem_q <= diff;
              quo_q <= {quo_q[W-2:0], 1'b1};
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quotient  <= '0;
      remainder <= '0;
      z         <= 1'b0;
      n         <= 1'b0;
      dz        <= 1'b0;
      v         <= 1'b0;
    end else if (state_q == FIX) begin
      quotient  <= q_fix;
      remainder <= r_fix;
      z         <= (q_fix == '0);
      n         <= sgn_q & q_fix[W-1];
      dz        <= dz_fix;
      v         <= ovf_fix;
    end
  end

  assign busy = (state_q == CALC) || (state_q == FIX);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_sequential_divider.sv
// Directed bench for sequential_divider at BUS_WIDTH=8.
// Expected values are hand-computed constants.
module tb_sequential_divider;

  logic       clk;
  logic       rst;
  logic       start;
  logic       sign;
  logic [7:0] in1;
  logic [7:0] in2;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       z;
  logic       n;
  logic       dz;
  logic       v;

  int checks = 0;
  int errors = 0;
  int lat;
  int pulses;

  sequential_divider #(.BUS_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sign      (sign),
    .in1       (in1),
    .in2       (in2),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .z         (z),
    .n         (n),
    .dz        (dz),
    .v         (v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic s, input logic [7:0] a,
                          input logic [7:0] b);
    @(negedge clk);
    sign  = s;
    in1   = a;
    in2   = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int base, output int l);
    l = -1;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        l = base + k;
        break;
      end
    end
  endtask

  task automatic chk_res(input string tag, input int q, input int r,
                         input int ez, input int en, input int edz,
                         input int ev);
    chk({tag, ".lat"}, lat, 10);
    chk({tag, ".q"}, int'(quotient), q);
    chk({tag, ".r"}, int'(remainder), r);
    chk({tag, ".z"}, int'(z), ez);
    chk({tag, ".n"}, int'(n), en);
    chk({tag, ".dz"}, int'(dz), edz);
    chk({tag, ".v"}, int'(v), ev);
    @(posedge clk);
    #1;
    chk({tag, ".done_1cyc"}, int'(done), 0);
    chk({tag, ".busy_idle"}, int'(busy), 0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    sign  = 1'b0;
    in1   = '0;
    in2   = '0;
    #12;
    chk("rst.busy", int'(busy), 0);
    chk("rst.done", int'(done), 0);
    chk("rst.q", int'(quotient), 0);
    chk("rst.r", int'(remainder), 0);
    chk("rst.flags", int'({z, n, dz, v}), 0);
    @(negedge clk);
    rst = 1'b0;

    start_op(1'b0, 8'd110, 8'd24);
    #1 chk("u110.busy", int'(busy), 1);
    wait_done(0, lat);
    chk_res("u110", 4, 14, 0, 0, 0, 0);

    start_op(1'b0, 8'd12, 8'd24);
    wait_done(0, lat);
    chk_res("u12", 0, 12, 1, 0, 0, 0);

    start_op(1'b1, 8'h92, 8'd24);
    wait_done(0, lat);
    chk_res("sneg", 8'hFC, 8'hF2, 0, 1, 0, 0);

    start_op(1'b1, 8'h92, 8'hE8);
    wait_done(0, lat);
    chk_res("snn", 4, 8'hF2, 0, 0, 0, 0);

    start_op(1'b1, 8'h6E, 8'hE8);
    wait_done(0, lat);
    chk_res("spn", 8'hFC, 8'h0E, 0, 1, 0, 0);

    start_op(1'b0, 8'd220, 8'd0);
    wait_done(0, lat);
    chk_res("dz", 8'hFF, 220, 0, 0, 1, 0);

    start_op(1'b1, 8'h80, 8'hFF);
    wait_done(0, lat);
    chk_res("ovf", 8'h80, 0, 0, 1, 0, 1);

    start_op(1'b0, 8'hFF, 8'h01);
    wait_done(0, lat);
    chk_res("uff", 8'hFF, 0, 0, 0, 0, 0);

    // second start mid-CALC must be ignored
    start_op(1'b0, 8'd200, 8'd7);
    repeat (3) @(posedge clk);
    #1;
    sign  = 1'b1;
    in1   = 8'd9;
    in2   = 8'd3;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(4, lat);
    chk_res("midst", 28, 4, 0, 0, 0, 0);
    pulses = 0;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    chk("midst.nopulse", pulses, 0);

    // async reset mid-CALC
    start_op(1'b0, 8'd100, 8'd3);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst.busy", int'(busy), 0);
    chk("arst.done", int'(done), 0);
    chk("arst.q", int'(quotient), 0);
    chk("arst.r", int'(remainder), 0);
    chk("arst.flags", int'({z, n, dz, v}), 0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) pulses++;
    end
    chk("arst.nopulse", pulses, 0);

    start_op(1'b0, 8'd9, 8'd3);
    wait_done(0, lat);
    chk_res("post", 3, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
